// File: rtl/mbist_response_checker.sv
// ---------------------------------------------------------------------------
// mbist_response_checker
//
// Purpose: compares the read data of one memory under test against the
// expected data that the BIST pattern generator supplied CHK_LAT cycles
// earlier. Expected data is captured into a CHK_LAT-deep pipeline.
// tst_check_ce must line up with the valid pipeline output. The block raises
// sticky flags for data mismatches, for strobe-protocol errors, and for
// completion.
//
// Optional feature: define MBIST_FAIL_LOG_EN to add a failure log. The log
// holds the address of the first mismatch and a saturating mismatch count.
// Without the macro, fail_addr and fail_cnt are tied to 0 and no log state
// is built.
//
// Ports:
//   bist_clk      in   BIST clock; all state changes on its rising edge
//   rst_h         in   asynchronous reset, active high
//   chk_en        in   this memory is selected for test
//   alg_end       in   end of the test algorithm
//   tst_capture   in   strobe that captures the expected data
//   tst_check_ce  in   strobe that checks the read data
//   tst_ADDRA     in   address of the captured access
//   tst_DIA/DIB   in   expected data for ports A and B
//   DOA/DOB       in   read data from the memory under test, ports A and B
//   inter_fail    out  sticky flag: a compare found a mismatch
//   inter_done    out  sticky flag: checking is complete
//   seq_err       out  sticky flag: strobe-protocol error
//   fail_addr     out  address of the first mismatch (log only)
//   fail_cnt      out  number of mismatching compares, saturates at 255
//                      (log only)
// ---------------------------------------------------------------------------
module mbist_response_checker #(
  parameter int ADDRA_W = 8,
  parameter int DA_W    = 35,
  parameter int DB_W    = 35,
  parameter int CHK_LAT = 2
) (
  input  logic             bist_clk,
  input  logic             rst_h,
  input  logic             chk_en,
  input  logic             alg_end,
  input  logic             tst_capture,
  input  logic             tst_check_ce,
  input  logic [ADDRA_W:0] tst_ADDRA,
  input  logic [DA_W:0]    tst_DIA,
  input  logic [DB_W:0]    tst_DIB,
  input  logic [DA_W:0]    DOA,
  input  logic [DB_W:0]    DOB,
  output logic             inter_fail,
  output logic             inter_done,
  output logic             seq_err,
  output logic [ADDRA_W:0] fail_addr,
  output logic [7:0]       fail_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int LAST = CHK_LAT - 1;

  logic [1:0]         state_q, state_d;
  logic [CHK_LAT-1:0] valid_q, valid_d;
  logic [DA_W:0]      da_q [CHK_LAT];
  logic [DA_W:0]      da_d [CHK_LAT];
  logic [DB_W:0]      db_q [CHK_LAT];
  logic [DB_W:0]      db_d [CHK_LAT];
  logic               inter_fail_q, inter_fail_d;
  logic               inter_done_q, inter_done_d;
  logic               seq_err_q, seq_err_d;

  logic shift_en;
  logic cap_ok;
  logic out_valid;
  logic do_cmp;
  logic mismatch;
  logic proto_err;

  // The pipeline moves only while the checker is active. Strobes that arrive
  // in IDLE or DONE have no effect.
  assign shift_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign cap_ok    = (state_q == ST_RUN) && tst_capture;
  assign out_valid = valid_q[LAST];
  assign do_cmp    = shift_en && tst_check_ce && out_valid;
  assign mismatch  = do_cmp && ((DOA != da_q[LAST]) || (DOB != db_q[LAST]));

  // A protocol error is one of three cases: a check with nothing to compare,
  // a valid entry that leaves the pipeline unchecked, or a capture while the
  // pipeline drains.
  assign proto_err = shift_en &&
                     ((tst_check_ce != out_valid) ||
                      ((state_q == ST_DRAIN) && tst_capture));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d = state_q;
    valid_d = valid_q;
    for (int k = 0; k < CHK_LAT; k++) begin
      da_d[k] = da_q[k];
      db_d[k] = db_q[k];
    end

    unique case (state_q)
      ST_IDLE:  if (chk_en) state_d = ST_RUN;
      // A capture in the cycle that ends RUN is still taken (cap_ok).
      ST_RUN:   if (alg_end || !chk_en) state_d = ST_DRAIN;
      ST_DRAIN: if (valid_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    if (shift_en) begin
      valid_d[0] = cap_ok;
      da_d[0]    = tst_DIA;
      db_d[0]    = tst_DIB;
      for (int k = 1; k < CHK_LAT; k++) begin
        valid_d[k] = valid_q[k-1];
        da_d[k]    = da_q[k-1];
        db_d[k]    = db_q[k-1];
      end
    end

    inter_fail_d = inter_fail_q | mismatch;
    seq_err_d    = seq_err_q | proto_err;
    inter_done_d = inter_done_q | (state_d == ST_DONE);
  end

  always_ff @(posedge bist_clk or posedge rst_h) begin
    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the values from before the clock edge, whatever order the
    // statements are in.
    if (rst_h) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      inter_fail_q <= 1'b0;
      inter_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      inter_fail_q <= inter_fail_d;
      inter_done_q <= inter_done_d;
      seq_err_q    <= seq_err_d;
    end
  end

  // NOTE: the pipeline data has no reset. Only the valid bits decide whether
  // a stage holds an entry, so the wide data stages do not need reset wiring.
  always_ff @(posedge bist_clk) begin
    da_q <= da_d;
    db_q <= db_d;
  end

  assign inter_fail = inter_fail_q;
  assign inter_done = inter_done_q;
  assign seq_err    = seq_err_q;

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDRA_W:0] addr_q [CHK_LAT];
  logic [ADDRA_W:0] addr_d [CHK_LAT];
  logic [ADDRA_W:0] fail_addr_q, fail_addr_d;
  logic [7:0]       fail_cnt_q, fail_cnt_d;

  always_comb begin
    for (int k = 0; k < CHK_LAT; k++) addr_d[k] = addr_q[k];
    if (shift_en) begin
      addr_d[0] = tst_ADDRA;
      for (int k = 1; k < CHK_LAT; k++) addr_d[k] = addr_q[k-1];
    end

    fail_addr_d = fail_addr_q;
    fail_cnt_d  = fail_cnt_q;
    // inter_fail_q is still clear on the first mismatch, so only that
    // mismatch records an address.
    if (mismatch && !inter_fail_q) fail_addr_d = addr_q[LAST];
    if (mismatch && (fail_cnt_q != 8'hFF)) fail_cnt_d = fail_cnt_q + 8'd1;
  end

  always_ff @(posedge bist_clk) begin
    addr_q <= addr_d;
  end

  always_ff @(posedge bist_clk or posedge rst_h) begin
    if (rst_h) begin
      fail_addr_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_cnt  = fail_cnt_q;
`else
  // The address only feeds the log. Without the log it is folded into a
  // signal that is intentionally left unused.
  logic unused_addr;
  assign unused_addr = ^tst_ADDRA;
  assign fail_addr   = '0;
  assign fail_cnt    = '0;
`endif

endmodule
